// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream frame packetizer: FSM encoding and a
// constant-time log2 helper used to size pointers and counters.
package axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STOP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with natural-wrap pointers and an occupancy counter.
// The caller guarantees wr_en is only raised when there is room (or a same-cycle read).
module axis_sync_fifo
  import axis_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/axis_frame_packetizer.sv
// Buffers a non-stallable sample feed and emits AXI-Stream frames with tlast every
// cfg_frame_len samples; stopping is deferred to a frame boundary.
module axis_frame_packetizer
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [LEN_W-1:0]      cfg_frame_len,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  ovf,
  input  logic                  ovf_clear
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  cnt, cnt_nxt, len_q, cfg_len, cur_len;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [DATA_WIDTH:0] fifo_dout;
  logic              accepting, pop, wr, wr_last, drop;

  assign cfg_len = (cfg_frame_len == '0) ? LEN_W'(1) : cfg_frame_len;
  assign cur_len = (cnt == '0) ? cfg_len : len_q;
  assign wr_last = (cnt == cur_len - LEN_W'(1));

  assign pop  = m_axis_tvalid && m_axis_tready;
  assign wr   = in_valid && accepting && (!fifo_full || pop);
  assign drop = in_valid && accepting && (fifo_count == CW'(DEPTH)) && !pop;

  assign cnt_nxt = wr ? (wr_last ? '0 : cnt + LEN_W'(1)) : cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Leaving RUN looks at the post-write counter so a sample written in the same
  // cycle either closes the frame (go to DRAIN) or is finished off in STOP.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable) state_nxt = ST_RUN;
      ST_RUN:   if (!enable) state_nxt = (cnt_nxt == '0) ? ST_DRAIN : ST_STOP;
      ST_STOP:  if (wr && wr_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    accepting = (state == ST_RUN) || (state == ST_STOP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      len_q <= LEN_W'(1);
      ovf   <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (wr && cnt == '0) len_q <= cfg_len;
      if (drop)           ovf <= 1'b1;
      else if (ovf_clear) ovf <= 1'b0;
    end
  end

  axis_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr),
    .din   ({wr_last, in_data}),
    .full  (fifo_full),
    .rd_en (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_dout[DATA_WIDTH-1:0];
  assign m_axis_tlast  = !fifo_empty && fifo_dout[DATA_WIDTH];

endmodule

// File: tb/tb_axis_frame_packetizer.sv
// Directed + randomized bench for axis_frame_packetizer against a queue-based
// frame model; every cycle compares the stream head, busy and ovf.
module tb_axis_frame_packetizer;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int LEN_W = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [LEN_W-1:0] cfg_frame_len = 8'd4;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          busy;
  logic          ovf;
  logic          ovf_clear = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of {tlast,data}, mode 0=idle 1=run 2=stop 3=drain
  logic [DW:0] q[$];
  int  mode = 0;
  int  fpos = 0;
  int  flen = 1;
  bit  movf = 0;

  always #5 clk = ~clk;

  axis_frame_packetizer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .cfg_frame_len (cfg_frame_len),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .ovf           (ovf),
    .ovf_clear     (ovf_clear)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [DW-1:0] d,
                      input bit en, input bit rdy, input bit clr);
    bit pop, acc, full, wr, drop, last;
    int len, cfg;
    logic [DW:0] head;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; enable = en; m_axis_tready = rdy; ovf_clear = clr;
    if (r) begin
      q.delete(); mode = 0; fpos = 0; flen = 1; movf = 0;
    end else begin
      cfg  = int'(cfg_frame_len);
      pop  = (q.size() != 0) && rdy;
      acc  = v && (mode == 1 || mode == 2);
      full = (q.size() == DEPTH);
      wr   = acc && (!full || pop);
      drop = acc && full && !pop;
      last = 0;
      if (wr) begin
        len = (fpos == 0) ? ((cfg == 0) ? 1 : cfg) : flen;
        if (fpos == 0) flen = len;
        last = (fpos == len - 1);
        fpos = last ? 0 : fpos + 1;
      end
      case (mode)
        0: if (en) mode = 1;
        1: if (!en) mode = (fpos == 0) ? 3 : 2;
        2: if (wr && last) mode = 3;
        default: if (q.size() == 0) mode = 0;
      endcase
      if (pop) void'(q.pop_front());
      if (wr) q.push_back({last, d});
      if (drop) movf = 1;
      else if (clr) movf = 0;
    end
    @(posedge clk);
    #1;
    head = (q.size() != 0) ? q[0] : '0;
    chk("tvalid", 32'(m_axis_tvalid), 32'(q.size() != 0));
    chk("tdata", 32'(m_axis_tdata), 32'(head[DW-1:0]));
    chk("tlast", 32'(m_axis_tlast), 32'(head[DW]));
    chk("busy", 32'(busy), 32'(mode != 0));
    chk("ovf", 32'(ovf), 32'(movf));
  endtask

  initial begin
    int bound;
    logic [DW-1:0] d;

    // reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // 1: len=4 streaming, tlast on 40 and 80
    cfg_frame_len = 8'd4;
    step(0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 8; i++) step(0, 1, DW'(i * 10), 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);

    // 2: stall 20 samples, 4 dropped, release, clear ovf
    for (int i = 0; i < 20; i++) step(0, 1, DW'($urandom), 1, 0, 0);
    chk("ovf_after_overflow", 32'(ovf), 32'd1);
    for (int i = 0; i < 18; i++) step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1);
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // 3: enable drops after 2nd sample of a frame
    step(0, 1, 16'h0101, 1, 1, 0);
    step(0, 1, 16'h0202, 1, 1, 0);
    step(0, 1, 16'h0303, 0, 1, 0);
    step(0, 1, 16'h0404, 0, 1, 0);
    step(0, 1, 16'h0505, 0, 1, 0);
    bound = 0;
    while (mode != 0 && bound < 40) begin step(0, 0, 0, 0, 1, 0); bound++; end
    chk("drain_bound", 32'(bound < 40), 32'd1);
    step(0, 0, 0, 0, 1, 0);
    chk("busy_after_drain", 32'(busy), 32'd0);

    // 4: full FIFO, simultaneous pop and write
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, DW'(16'h1000 + i), 1, 0, 0);
    step(0, 1, 16'h2000, 1, 1, 0);
    chk("ovf_full_pop_write", 32'(ovf), 32'd0);
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 1, 1, 0);

    // 5: random traffic, random tready, varying frame lengths incl. 0
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: cfg_frame_len = 8'd0;
        1: cfg_frame_len = 8'd1;
        2: cfg_frame_len = 8'd3;
        3: cfg_frame_len = 8'd4;
        default: cfg_frame_len = 8'd7;
      endcase
      d = DW'($urandom);
      step(0, $urandom_range(0, 3) != 0, d, $urandom_range(0, 15) != 0,
           $urandom_range(0, 1) != 0, $urandom_range(0, 30) == 0);
    end

    // 6: reset mid-frame with 5 entries queued
    cfg_frame_len = 8'd4;
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, DW'(16'h3000 + i), 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("tvalid_after_rst", 32'(m_axis_tvalid), 32'd0);
    chk("busy_after_rst", 32'(busy), 32'd0);
    step(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, DW'(16'h4000 + i), 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
